// File: rtl/nibble_packer.sv
// Packs NIBBLES consecutive DATA_W-bit beats into one registered output word,
// with a flush that emits a partially filled word and full valid/ready handshaking.
module nibble_packer #(
   parameter int  DATA_W    = 4,
   parameter int  NIBBLES   = 2,
   parameter bit  LSB_FIRST = 1'b1,
   localparam int WORD_W    = DATA_W * NIBBLES,
   localparam int CNT_W     = $clog2(NIBBLES),
   localparam int NV_W      = $clog2(NIBBLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   input  logic              busy,
   input  logic              flush_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] data_o,
   output logic [NV_W-1:0]   nvalid_o,
   output logic              partial_o,
   input  logic              ready_i
);

   typedef enum logic {FILL, FLUSH} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [WORD_W-1:0]   acc;
   logic [WORD_W-1:0]   acc_next;
   logic [CNT_W-1:0]    slot;
   logic [NV_W-1:0]     fill_cnt;
   logic                obuf_free;
   logic                at_last;
   logic                accept;

   always_comb begin
      // NOTE: every signal gets a default before any conditional update so no latch is inferred.
      obuf_free = !valid_o || ready_i;
      at_last   = (cnt == LAST);
      ready_o   = !busy && (state == FILL) && (!at_last || obuf_free);
      accept    = valid_i && ready_o;
      slot      = LSB_FIRST ? cnt : (LAST - cnt);
      fill_cnt  = NV_W'(cnt) + NV_W'(accept);
      acc_next  = acc;
      if (accept) begin
         for (int s = 0; s < NIBBLES; s++) begin
            if (slot == CNT_W'(s)) acc_next[s*DATA_W +: DATA_W] = data_i;
         end
      end
   end

   // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FILL;
         cnt       <= '0;
         acc       <= '0;
         valid_o   <= 1'b0;
         data_o    <= '0;
         nvalid_o  <= '0;
         partial_o <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept && at_last) begin
                  // A completed word also satisfies any flush raised in the same cycle.
                  valid_o   <= 1'b1;
                  data_o    <= acc_next;
                  nvalid_o  <= NV_W'(NIBBLES);
                  partial_o <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
               end else if (flush_i && (cnt != '0 || accept)) begin
                  if (obuf_free) begin
                     valid_o   <= 1'b1;
                     data_o    <= acc_next;
                     nvalid_o  <= fill_cnt;
                     partial_o <= 1'b1;
                     acc       <= '0;
                     cnt       <= '0;
                  end else begin
                     acc   <= acc_next;
                     cnt   <= CNT_W'(fill_cnt);
                     state <= FLUSH;
                  end
               end else begin
                  if (accept) begin
                     acc <= acc_next;
                     cnt <= cnt + CNT_W'(1);
                  end
                  if (ready_i) valid_o <= 1'b0;
               end
            end
            FLUSH: begin
               if (obuf_free) begin
                  valid_o   <= 1'b1;
                  data_o    <= acc;
                  nvalid_o  <= NV_W'(cnt);
                  partial_o <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
